// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle
//  Purpose  : RV32IM execute unit. Single-cycle RV32I ALU operations plus
//             iterative M-extension multiply (shift-add) and divide/remainder
//             (restoring). A start/busy/valid handshake lets the pipeline
//             stall while an iterative operation runs. Result and Zero are
//             registered and hold until the next result is produced.
//  Ports    : clk, rst        - clock (rising edge), async active-high reset
//             Start           - request, sampled only while idle
//             Flush           - abort any in-flight operation (beats Start)
//             ALUControl      - operation select
//             SrcA, SrcB, PC  - operands and program counter
//             Busy            - high whenever the FSM is not idle
//             Valid           - one-cycle pulse, result ready
//             ALUResult, Zero - registered result and (result == 0) flag
//  Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 5,
  parameter int SHIFT_WIDTH    = 5,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Start,
  input  logic                      Flush,
  input  logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  input  logic [DATA_WIDTH-1:0]     SrcA,
  input  logic [DATA_WIDTH-1:0]     SrcB,
  input  logic [DATA_WIDTH-1:0]     PC,
  output logic                      Busy,
  output logic                      Valid,
  output logic [DATA_WIDTH-1:0]     ALUResult,
  output logic                      Zero
);

  localparam int W = DATA_WIDTH;

  localparam logic [ALU_CTRL_WIDTH-1:0] OP_ADD    = ALU_CTRL_WIDTH'(5'b00000);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB    = ALU_CTRL_WIDTH'(5'b00001);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLL    = ALU_CTRL_WIDTH'(5'b00010);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLT    = ALU_CTRL_WIDTH'(5'b00011);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLTU   = ALU_CTRL_WIDTH'(5'b00100);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_XOR    = ALU_CTRL_WIDTH'(5'b00101);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRL    = ALU_CTRL_WIDTH'(5'b00110);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRA    = ALU_CTRL_WIDTH'(5'b00111);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR     = ALU_CTRL_WIDTH'(5'b01000);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND    = ALU_CTRL_WIDTH'(5'b01001);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_AUIPC  = ALU_CTRL_WIDTH'(5'b01010);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_LUI    = ALU_CTRL_WIDTH'(5'b01011);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_PC4    = ALU_CTRL_WIDTH'(5'b01100);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MUL    = ALU_CTRL_WIDTH'(5'b10000);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MULH   = ALU_CTRL_WIDTH'(5'b10001);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MULHSU = ALU_CTRL_WIDTH'(5'b10010);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MULHU  = ALU_CTRL_WIDTH'(5'b10011);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_DIV    = ALU_CTRL_WIDTH'(5'b10100);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_DIVU   = ALU_CTRL_WIDTH'(5'b10101);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_REM    = ALU_CTRL_WIDTH'(5'b10110);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_REMU   = ALU_CTRL_WIDTH'(5'b10111);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [W-1:0]         MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         mag_q, mag_d;       // multiplicand or divisor magnitude
  logic [2*W-1:0]       acc_q, acc_d;       // {hi, lo} working accumulator
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 negq_q, negq_d;     // negate product / quotient
  logic                 negr_q, negr_d;     // negate remainder
  logic                 sel_q, sel_d;       // mul: high half, div: remainder
  logic [W-1:0]         result_q, result_d;
  logic                 zero_q, zero_d;

  // --------------------------------------------------------------------------
  // Opcode decode
  // --------------------------------------------------------------------------
  logic is_mul, is_div, a_signed, b_signed, div_rem;
  logic a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  assign is_mul  = (ALUControl == OP_MUL)  || (ALUControl == OP_MULH) ||
                   (ALUControl == OP_MULHSU) || (ALUControl == OP_MULHU);
  assign is_div  = (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU) ||
                   (ALUControl == OP_REM)  || (ALUControl == OP_REMU);
  assign div_rem = (ALUControl == OP_REM)  || (ALUControl == OP_REMU);

  assign a_signed = is_mul ? ((ALUControl == OP_MULH) || (ALUControl == OP_MULHSU))
                           : ((ALUControl == OP_DIV)  || (ALUControl == OP_REM));
  assign b_signed = is_mul ? (ALUControl == OP_MULH)
                           : ((ALUControl == OP_DIV)  || (ALUControl == OP_REM));

  assign a_neg = a_signed & SrcA[W-1];
  assign b_neg = b_signed & SrcB[W-1];
  // The most-negative value maps onto itself, which is the correct unsigned
  // magnitude 2^(W-1).
  assign a_mag = a_neg ? -SrcA : SrcA;
  assign b_mag = b_neg ? -SrcB : SrcB;

  // --------------------------------------------------------------------------
  // Single-cycle ALU
  // --------------------------------------------------------------------------
  logic [SHIFT_WIDTH-1:0] shamt;
  logic [W-1:0]           alu_res;

  assign shamt = SrcB[SHIFT_WIDTH-1:0];

  always_comb begin
    alu_res = SrcA + SrcB;
    case (ALUControl)
      OP_ADD:   alu_res = SrcA + SrcB;
      OP_SUB:   alu_res = SrcA - SrcB;
      OP_SLL:   alu_res = SrcA << shamt;
      OP_SLT:   alu_res = {{(W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU:  alu_res = {{(W-1){1'b0}}, (SrcA < SrcB)};
      OP_XOR:   alu_res = SrcA ^ SrcB;
      OP_SRL:   alu_res = SrcA >> shamt;
      OP_SRA:   alu_res = W'($signed(SrcA) >>> shamt);
      OP_OR:    alu_res = SrcA | SrcB;
      OP_AND:   alu_res = SrcA & SrcB;
      OP_AUIPC: alu_res = (SrcB << 12) + PC;
      OP_LUI:   alu_res = SrcB << 12;
      OP_PC4:   alu_res = PC + W'(4);
      default:  alu_res = SrcA + SrcB;
    endcase
  end

  // --------------------------------------------------------------------------
  // Multiply step: acc lo holds the remaining multiplier bits, acc hi the
  // running partial sum; each cycle adds the multiplicand if the current
  // multiplier bit is set, then shifts the whole pair right.
  // --------------------------------------------------------------------------
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next, mul_prod;
  logic [W-1:0]   mul_res;

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};
  assign mul_prod = negq_q ? -mul_next : mul_next;
  assign mul_res  = sel_q ? mul_prod[2*W-1:W] : mul_prod[W-1:0];

  // --------------------------------------------------------------------------
  // Restoring divide step: acc hi is the partial remainder, acc lo shifts the
  // dividend out at the top and the quotient bits in at the bottom.
  // --------------------------------------------------------------------------
  logic [W:0]     rem_sh, div_diff;
  logic           qbit;
  logic [2*W-1:0] div_next;
  logic [W-1:0]   quot, remd, div_res;

  assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff = rem_sh - {1'b0, mag_q};
  assign qbit     = ~div_diff[W];
  assign div_next = {(qbit ? div_diff[W-1:0] : rem_sh[W-1:0]), acc_q[W-2:0], qbit};
  assign quot     = div_next[W-1:0];
  assign remd     = div_next[2*W-1:W];
  assign div_res  = sel_q ? (negr_q ? -remd : remd) : (negq_q ? -quot : quot);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    sel_d    = sel_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (Start && !Flush) begin
          cnt_d  = '0;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          if (is_mul) begin
            mag_d   = a_mag;
            acc_d   = {{W{1'b0}}, b_mag};
            sel_d   = (ALUControl != OP_MUL);
            state_d = S_MUL;
          end else if (is_div) begin
            sel_d = div_rem;
            if (SrcB == '0) begin
              result_d = div_rem ? SrcA : '1;
              state_d  = S_DONE;
            end else if (a_signed && (SrcA == MOST_NEG) && (SrcB == '1)) begin
              result_d = div_rem ? '0 : MOST_NEG;
              state_d  = S_DONE;
            end else begin
              mag_d   = b_mag;
              acc_d   = {{W{1'b0}}, a_mag};
              state_d = S_DIV;
            end
          end else begin
            result_d = alu_res;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = mul_res;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = div_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;  // S_DONE: Valid is this single cycle
    endcase

    if (Flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    // Zero tracks the result register exactly, so it only moves with it.
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      sel_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Valid     = (state_q == S_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_multicycle
//  Purpose  : Self-checking bench for alu_multicycle. Expected results are
//             queued when an operation is issued and compared when Valid
//             pulses; latency, Busy duration, Start-while-busy, Flush and
//             mid-operation reset are checked as well.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start, Flush;
  logic [4:0]  ALUControl;
  logic [31:0] SrcA, SrcB, PC;
  logic        Busy, Valid, Zero;
  logic [31:0] ALUResult;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  alu_multicycle #(
    .DATA_WIDTH(32), .ALU_CTRL_WIDTH(5), .SHIFT_WIDTH(5), .CNT_WIDTH(6)
  ) dut (
    .clk(clk), .rst(rst), .Start(Start), .Flush(Flush),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .PC(PC),
    .Busy(Busy), .Valid(Valid), .ALUResult(ALUResult), .Zero(Zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one request; returns sampled in cycle 1 after the accept edge.
  task automatic start_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc);
    @(negedge clk);
    ALUControl = op; SrcA = a; SrcB = b; PC = pc; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] want, input int lat);
    int n, busy_n;
    logic [31:0] e;
    exp_q.push_back(want);
    start_op(op, a, b, pc);
    n = 1; busy_n = 0;
    while (!Valid && n < 100) begin
      if (Busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    if (Busy) busy_n++;
    e = exp_q.pop_front();
    chk({tag, "_res"}, ALUResult, e);
    chk({tag, "_zero"}, 32'(Zero), 32'(e == 32'h0));
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_busy"}, 32'(busy_n), 32'(lat));
    @(posedge clk); #1;
    chk({tag, "_vpulse"}, 32'(Valid), 32'h0);
    chk({tag, "_idle"}, 32'(Busy), 32'h0);
  endtask

  initial begin
    int nv, fv;
    logic [31:0] e;

    rst = 1'b1; Start = 1'b0; Flush = 1'b0;
    ALUControl = '0; SrcA = '0; SrcB = '0; PC = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(Busy),  32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    chk("rst_res",   ALUResult,  32'h0);
    chk("rst_zero",  32'(Zero),  32'h1);
    rst = 1'b0;

    // Single-cycle operations
    issue("add",   5'b00000, 32'd5,        32'd7,  32'h0,   32'd12,        1);
    issue("sub",   5'b00001, 32'd7,        32'd7,  32'h0,   32'd0,         1);
    issue("slt",   5'b00011, 32'hFFFFFFFF, 32'd1,  32'h0,   32'd1,         1);
    issue("sltu",  5'b00100, 32'hFFFFFFFF, 32'd1,  32'h0,   32'd0,         1);
    issue("sra",   5'b00111, 32'h80000000, 32'd4,  32'h0,   32'hF8000000,  1);
    issue("srl",   5'b00110, 32'h80000000, 32'h24, 32'h0,   32'h08000000,  1);
    issue("sll",   5'b00010, 32'h00000003, 32'd31, 32'h0,   32'h80000000,  1);
    issue("xor",   5'b00101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0FF00FF0, 1);
    issue("or",    5'b01000, 32'hF0F00000, 32'h0000F0F0, 32'h0, 32'hF0F0F0F0, 1);
    issue("and",   5'b01001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 1);
    issue("auipc", 5'b01010, 32'h0,        32'd1,  32'h100, 32'h00001100,  1);
    issue("lui",   5'b01011, 32'h0,        32'hABCDE, 32'h100, 32'hABCDE000, 1);
    issue("pc4",   5'b01100, 32'h0,        32'h0,  32'hFFFFFFFC, 32'h0,    1);
    issue("undef", 5'b11101, 32'hFFFFFFFF, 32'd2,  32'h0,   32'd1,         1);

    // Iterative multiply
    issue("mul",    5'b10000, 32'hFFFFFFFF, 32'd3, 32'h0, 32'hFFFFFFFD, 33);
    issue("mulh",   5'b10001, 32'hFFFFFFFF, 32'd3, 32'h0, 32'hFFFFFFFF, 33);
    issue("mulhu",  5'b10011, 32'hFFFFFFFF, 32'd3, 32'h0, 32'h00000002, 33);
    issue("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'd3, 32'h0, 32'hFFFFFFFF, 33);
    issue("mulh_mn",5'b10001, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 33);

    // Iterative divide
    issue("div",   5'b10100, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFD, 33);
    issue("rem",   5'b10110, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFF, 33);
    issue("divu",  5'b10101, 32'd100,      32'd7, 32'h0, 32'd14,       33);
    issue("remu",  5'b10111, 32'd100,      32'd7, 32'h0, 32'd2,        33);
    issue("div_nb",5'b10100, 32'd7,  32'hFFFFFFFE, 32'h0, 32'hFFFFFFFD, 33);
    issue("rem_nb",5'b10110, 32'd7,  32'hFFFFFFFE, 32'h0, 32'd1,        33);

    // Divide special cases
    issue("divu0", 5'b10101, 32'd5,        32'd0,        32'h0, 32'hFFFFFFFF, 1);
    issue("remu0", 5'b10111, 32'd5,        32'd0,        32'h0, 32'd5,        1);
    issue("divov", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1);
    issue("remov", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'd0,        1);

    // Start re-pulsed while busy must be ignored and not queued
    exp_q.push_back(32'hFFFFFFFD);
    start_op(5'b10100, 32'hFFFFFFF9, 32'd2, 32'h0);
    nv = 0; fv = 0;
    for (int c = 1; c <= 45; c++) begin
      if (Valid) begin
        nv++;
        if (fv == 0) fv = c;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        chk("repulse_res", ALUResult, e);
      end
      Start = (c == 10);
      ALUControl = 5'b00000; SrcA = 32'd1; SrcB = 32'd1;
      @(posedge clk); #1;
    end
    Start = 1'b0;
    chk("repulse_nvalid", 32'(nv), 32'd1);
    chk("repulse_cycle",  32'(fv), 32'd33);

    // Flush mid-divide: back to idle, no Valid, result held
    start_op(5'b10101, 32'd100, 32'd7, 32'h0);
    for (int c = 1; c < 12; c++) begin
      @(posedge clk); #1;
    end
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    chk("flush_busy", 32'(Busy), 32'h0);
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (Valid) nv++;
      @(posedge clk); #1;
    end
    chk("flush_nvalid", 32'(nv), 32'd0);
    chk("flush_res",    ALUResult, 32'hFFFFFFFD);
    chk("flush_zero",   32'(Zero), 32'h0);

    // Flush in idle beats Start
    @(negedge clk);
    ALUControl = 5'b00000; SrcA = 32'd1; SrcB = 32'd2; Start = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    chk("flushstart_busy", 32'(Busy), 32'h0);
    chk("flushstart_res",  ALUResult, 32'hFFFFFFFD);

    // Async reset in the middle of a multiply
    start_op(5'b10000, 32'd9, 32'd9, 32'h0);
    for (int c = 1; c < 5; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("mrst_busy",  32'(Busy),  32'h0);
    chk("mrst_valid", 32'(Valid), 32'h0);
    chk("mrst_res",   ALUResult,  32'h0);
    chk("mrst_zero",  32'(Zero),  32'h1);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (Valid) nv++;
      @(posedge clk); #1;
    end
    chk("mrst_nvalid", 32'(nv), 32'd0);

    // Recovery after reset
    issue("post_add", 5'b00000, 32'h7FFFFFFF, 32'd1, 32'h0, 32'h80000000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
